// File: rtl/leaf_user_pkg.sv
// Shared definitions for the leaf shell user-side adapters (transmit and receive).
// Contents:
//   LEAF_PAYLOAD_BITS  default width of one data word, matching leaf_interface
//   LEAF_FIFO_DEPTH    default adapter FIFO depth
//   LEAF_CNT_BITS      default width of the statistics counters
//   user_word_t        one data word at the default width
package leaf_user_pkg;

  localparam int LEAF_PAYLOAD_BITS = 32;
  localparam int LEAF_FIFO_DEPTH   = 4;
  localparam int LEAF_CNT_BITS     = 32;

  typedef logic [LEAF_PAYLOAD_BITS-1:0] user_word_t;

endpackage

// File: rtl/leaf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous active-high reset.
// dout always shows the head entry whenever empty is low; rd_en pops it.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, empties the FIFO
//   wr_en  in   write din (ignored while full)
//   din    in   WIDTH  write data
//   full   out  no free entry
//   rd_en  in   pop the head entry (ignored while empty)
//   dout   out  WIDTH  head entry
//   empty  out  no entry stored
//   level  out  $clog2(DEPTH+1)  number of stored entries
module leaf_sync_fifo
  import leaf_user_pkg::*;
#(
  parameter int WIDTH = LEAF_PAYLOAD_BITS,
  parameter int DEPTH = LEAF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is not reset: the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_user2interface_tx.sv
// Transmit-side adapter between a user kernel output stream and one leaf_interface
// output port, clk_user domain. Kernel words are buffered in a FWFT FIFO and then
// moved into an output register that drives the leaf_interface valid/ack handshake.
// Ports:
//   clk_user                 in   user clock, rising edge
//   reset                    in   synchronous active-high reset
//   s_tdata                  in   PAYLOAD_BITS  kernel word
//   s_tvalid                 in   kernel word valid
//   s_tready                 out  word accepted this cycle when s_tvalid is high
//   din_leaf_user2interface  out  PAYLOAD_BITS  word presented to leaf_interface
//   vld_user2interface       out  din_leaf_user2interface is valid
//   ack_interface2user       in   leaf_interface takes the word this cycle
//   fifo_level               out  FIFO occupancy, output register not included
//   sent_count               out  CNT_BITS  transfers to leaf_interface, wrapping
//   stall_count              out  CNT_BITS  cycles with vld high and ack low, saturating
module leaf_user2interface_tx #(
  parameter int PAYLOAD_BITS = leaf_user_pkg::LEAF_PAYLOAD_BITS,
  parameter int FIFO_DEPTH   = leaf_user_pkg::LEAF_FIFO_DEPTH,
  parameter int CNT_BITS     = leaf_user_pkg::LEAF_CNT_BITS
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [PAYLOAD_BITS-1:0]         s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  output logic [PAYLOAD_BITS-1:0]         din_leaf_user2interface,
  output logic                            vld_user2interface,
  input  logic                            ack_interface2user,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [CNT_BITS-1:0]             sent_count,
  output logic [CNT_BITS-1:0]             stall_count
);

  import leaf_user_pkg::*;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] fifo_dout;
  logic                    fifo_wr;
  logic                    load;
  logic                    xfer;
  logic                    stall;

  // Readiness depends only on fullness: a pop in the same cycle does not open a slot.
  assign s_tready = !reset && !fifo_full;
  assign fifo_wr  = s_tvalid && s_tready;

  assign xfer  = vld_user2interface && ack_interface2user;
  assign stall = vld_user2interface && !ack_interface2user;
  // Output register refills when it is empty or being emptied this cycle.
  assign load  = (!vld_user2interface || ack_interface2user) && !fifo_empty;

  leaf_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_user),
    .reset (reset),
    .wr_en (fifo_wr),
    .din   (s_tdata),
    .full  (fifo_full),
    .rd_en (load),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_user) begin
    if (reset) begin
      vld_user2interface      <= 1'b0;
      din_leaf_user2interface <= '0;
    end else if (load) begin
      vld_user2interface      <= 1'b1;
      din_leaf_user2interface <= fifo_dout;
    end else if (xfer) begin
      vld_user2interface      <= 1'b0;
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      sent_count  <= '0;
      stall_count <= '0;
    end else begin
      if (xfer) sent_count <= sent_count + 1'b1;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_user2interface_tx.sv
module tb_leaf_user2interface_tx;

  localparam int PB    = 32;
  localparam int DEPTH = 4;
  localparam int CB    = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk_user = 1'b0;
  logic          reset;
  logic [PB-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [PB-1:0] din;
  logic          vld;
  logic          ack;
  logic [LW-1:0] fifo_level;
  logic [CB-1:0] sent_count;
  logic [CB-1:0] stall_count;

  always #5 clk_user = ~clk_user;

  leaf_user2interface_tx #(
    .PAYLOAD_BITS (PB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_BITS     (CB)
  ) dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .s_tdata                 (s_tdata),
    .s_tvalid                (s_tvalid),
    .s_tready                (s_tready),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .fifo_level              (fifo_level),
    .sent_count              (sent_count),
    .stall_count             (stall_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: words buffered before the output stage, the output stage itself,
  // and a separate list of every accepted word not yet handed over.
  logic [PB-1:0] m_fifo [$];
  logic [PB-1:0] sb_q [$];
  logic          m_vld   = 1'b0;
  logic [PB-1:0] m_din   = '0;
  logic [CB-1:0] m_sent  = '0;
  logic [CB-1:0] m_stall = '0;
  logic          last_push = 1'b0;
  logic          prev_hold = 1'b0;
  logic [PB-1:0] prev_din  = '0;
  int            n_acc = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the reference, cross the edge.
  task automatic step();
    logic exp_rdy, mxfer, mstall, mpush, mload;
    @(negedge clk_user);
    exp_rdy = !reset && (m_fifo.size() < DEPTH);
    check_val("s_tready", s_tready, exp_rdy);
    check_val("vld", vld, m_vld);
    check_val("din", din, m_din);
    check_val("fifo_level", fifo_level, m_fifo.size());
    check_val("sent_count", sent_count, m_sent);
    check_val("stall_count", stall_count, m_stall);
    if (prev_hold) begin
      check_val("hold_vld", vld, 1);
      check_val("hold_din", din, prev_din);
    end
    if (s_tvalid && s_tready) n_acc++;
    if (!reset && vld && ack) begin
      if (sb_q.size() == 0) check_val("sb_underflow", sb_q.size(), 1);
      else                  check_val("sb_order", din, sb_q.pop_front());
    end
    prev_hold = !reset && vld && !ack;
    prev_din  = din;

    if (reset) begin
      m_fifo.delete();
      sb_q.delete();
      m_vld = 1'b0; m_din = '0; m_sent = '0; m_stall = '0;
      last_push = 1'b0;
    end else begin
      mxfer  = m_vld && ack;
      mstall = m_vld && !ack;
      mpush  = s_tvalid && (m_fifo.size() < DEPTH);
      mload  = (!m_vld || ack) && (m_fifo.size() > 0);
      if (mload) begin
        m_din = m_fifo.pop_front();
        m_vld = 1'b1;
      end else if (mxfer) begin
        m_vld = 1'b0;
      end
      if (mpush) begin
        m_fifo.push_back(s_tdata);
        sb_q.push_back(s_tdata);
      end
      if (mxfer) m_sent = m_sent + 1'b1;
      if (mstall && (m_stall != '1)) m_stall = m_stall + 1'b1;
      last_push = mpush;
    end
    @(posedge clk_user);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; s_tvalid = 1'b0; ack = 1'b0;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    int acc0, words, cyc;
    reset = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h1234_5678; ack = 1'b0;
    @(posedge clk_user);
    #1;

    // Reset held with a valid word offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0; s_tvalid = 1'b0;
    check_val("rst_vld", vld, 0);
    check_val("rst_din", din, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_sent", sent_count, 0);
    check_val("rst_stall", stall_count, 0);

    // Latency: accepted in cycle N, visible in N+2, counted in N+3.
    for (int i = 0; i < 6; i++) step();
    ack = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
    step();
    s_tvalid = 1'b0;
    check_val("lat_vld_n1", vld, 0);
    step();
    check_val("lat_vld_n2", vld, 1);
    check_val("lat_din_n2", din, 32'hDEAD_BEEF);
    step();
    check_val("lat_sent_n3", sent_count, 1);
    check_val("lat_vld_n3", vld, 0);

    // Backpressure: capacity is FIFO_DEPTH words plus the output register.
    do_reset(1);
    ack = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1; s_tdata = i;
      step();
    end
    s_tvalid = 1'b0;
    check_val("bp_accepted", n_acc - acc0, 5);
    check_val("bp_level", fifo_level, DEPTH);
    check_val("bp_ready", s_tready, 0);
    check_val("bp_head", din, 0);
    ack = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check_val("bp_sent", sent_count, 5);

    // Streaming 0..99 with both sides always ready.
    do_reset(1);
    ack = 1'b1;
    words = 0; cyc = 0;
    while (words < 100 && cyc < 300) begin
      s_tvalid = 1'b1; s_tdata = words;
      step();
      if (last_push) words++;
      cyc++;
    end
    s_tvalid = 1'b0;
    check_val("stream_cycles", cyc, 100);
    for (int i = 0; i < 3; i++) step();
    check_val("stream_sent", sent_count, 100);
    check_val("stream_stall", stall_count, 0);

    // Random valid/ack, 10k words.
    do_reset(1);
    words = 0; cyc = 0;
    while (words < 10000 && cyc < 60000) begin
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = $urandom;
      ack      = 1'($urandom_range(0, 1));
      step();
      if (last_push) words++;
      cyc++;
    end
    check_val("rand_words", words, 10000);
    s_tvalid = 1'b0; ack = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) step();
    check_val("rand_sent", sent_count, 10000);
    check_val("rand_drained", sb_q.size(), 0);

    // Reset in the middle of a burst drops everything buffered.
    do_reset(1);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hA000_0000 + i;
      step();
    end
    s_tvalid = 1'b0;
    check_val("mid_level", fifo_level, 3);
    check_val("mid_vld", vld, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_rst_vld", vld, 0);
    check_val("mid_rst_level", fifo_level, 0);
    check_val("mid_rst_sent", sent_count, 0);
    check_val("mid_rst_stall", stall_count, 0);
    ack = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h600D_F00D;
    step();
    s_tvalid = 1'b0;
    step();
    check_val("mid_first_out", din, 32'h600D_F00D);
    check_val("mid_first_vld", vld, 1);
    step();
    step();
    check_val("mid_sent", sent_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
